// File: rtl/id_hazard_redirect_ctrl.sv
// Decode-stage hazard/redirect controller: load-use and branch-operand stalls, MEM/WB operand
// forwarding, and multi-slot IF/ID squash after redirects. Define HAZARD_STATS_EN for stall/redirect counters.
`default_nettype none
module id_hazard_redirect_ctrl #(
  parameter int REG_AW      = 5,
  parameter int LOAD_LAT    = 1,
  parameter int FLUSH_SLOTS = 1,
  parameter int CNT_W       = 32
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              IDValid,
  input  logic [REG_AW-1:0] IDRs,
  input  logic [REG_AW-1:0] IDRt,
  input  logic              IDUsesRs,
  input  logic              IDUsesRt,
  input  logic              IDIsBranch,
  input  logic              IDIsJump,
  input  logic              IDIsJumpReg,
  input  logic              BranchTaken,
  input  logic              EXRegWrite,
  input  logic              EXMemRead,
  input  logic [REG_AW-1:0] EXDest,
  input  logic              MEMRegWrite,
  input  logic              MEMMemRead,
  input  logic [REG_AW-1:0] MEMDest,
  input  logic              WBRegWrite,
  input  logic [REG_AW-1:0] WBDest,
  output logic [1:0]        FwdSelA,
  output logic [1:0]        FwdSelB,
  output logic              PCWriteEnable,
  output logic              IFIDWriteEnable,
  output logic              IDEXFlush,
  output logic              IFIDFlush,
  output logic              Redirect,
  output logic [CNT_W-1:0]  StallCycles,
  output logic [CNT_W-1:0]  RedirectCount
);
  localparam int MAX_LEFT = (LOAD_LAT + 1 > FLUSH_SLOTS) ? LOAD_LAT + 1 : FLUSH_SLOTS;
  localparam int LEFT_W   = $clog2(MAX_LEFT + 1);

  typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, FLUSH = 2'd2} state_t;

  state_t            state, state_n;
  logic [LEFT_W-1:0] left, left_n;
  logic [LEFT_W-1:0] haz_len;
  logic              need_id, take;
  logic              ex_hit, mem_hit;
  logic              mem_rs, mem_rt, wb_rs, wb_rt;

  function automatic logic match(input logic valid, input logic uses,
                                 input logic [REG_AW-1:0] src, input logic [REG_AW-1:0] dst);
    return valid & uses & (dst != '0) & (dst == src);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic mem_m, input logic wb_m);
    if (MEMRegWrite & ~MEMMemRead & mem_m) return 2'd1;
    else if (WBRegWrite & wb_m)            return 2'd2;
    else                                   return 2'd0;
  endfunction

  assign need_id = IDIsBranch | IDIsJumpReg;
  assign take    = IDValid & (IDIsJump | (IDIsBranch & BranchTaken));
  assign ex_hit  = match(IDValid, IDUsesRs, IDRs, EXDest)  | match(IDValid, IDUsesRt, IDRt, EXDest);
  assign mem_rs  = match(IDValid, IDUsesRs, IDRs, MEMDest);
  assign mem_rt  = match(IDValid, IDUsesRt, IDRt, MEMDest);
  assign wb_rs   = match(IDValid, IDUsesRs, IDRs, WBDest);
  assign wb_rt   = match(IDValid, IDUsesRt, IDRt, WBDest);
  assign mem_hit = mem_rs | mem_rt;

  // Later assignments are always at least as long, so the last hit is the maximum.
  always_comb begin
    haz_len = '0;
    if (mem_hit & MEMMemRead & need_id)              haz_len = LEFT_W'(1);
    if (ex_hit & EXRegWrite & ~EXMemRead & need_id)  haz_len = LEFT_W'(1);
    if (ex_hit & EXMemRead)                          haz_len = LEFT_W'(LOAD_LAT) + LEFT_W'(need_id);
  end

  always_comb begin
    state_n         = state;
    left_n          = left;
    PCWriteEnable   = 1'b1;
    IFIDWriteEnable = 1'b1;
    IDEXFlush       = 1'b0;
    IFIDFlush       = 1'b0;
    Redirect        = 1'b0;
    FwdSelA         = fwd_sel(mem_rs, wb_rs);
    FwdSelB         = fwd_sel(mem_rt, wb_rt);
    case (state)
      RUN: begin
        if (haz_len != '0) begin
          PCWriteEnable   = 1'b0;
          IFIDWriteEnable = 1'b0;
          IDEXFlush       = 1'b1;
          if (haz_len > LEFT_W'(1)) begin
            state_n = STALL;
            left_n  = haz_len - LEFT_W'(1);
          end
        end else if (take) begin
          Redirect  = 1'b1;
          IFIDFlush = 1'b1;
          if (FLUSH_SLOTS > 1) begin
            state_n = FLUSH;
            left_n  = LEFT_W'(FLUSH_SLOTS - 1);
          end
        end
      end
      STALL: begin
        PCWriteEnable   = 1'b0;
        IFIDWriteEnable = 1'b0;
        IDEXFlush       = 1'b1;
        left_n          = left - LEFT_W'(1);
        if (left == LEFT_W'(1)) state_n = RUN;
      end
      FLUSH: begin
        IFIDFlush = 1'b1;
        left_n    = left - LEFT_W'(1);
        if (left == LEFT_W'(1)) state_n = RUN;
      end
      default: begin
        state_n = RUN;
        left_n  = '0;
      end
    endcase
    if (Reset) begin
      PCWriteEnable   = 1'b0;
      IFIDWriteEnable = 1'b0;
      IDEXFlush       = 1'b1;
      IFIDFlush       = 1'b1;
      Redirect        = 1'b0;
      FwdSelA         = 2'd0;
      FwdSelB         = 2'd0;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= RUN;
      left  <= '0;
    end else begin
      state <= state_n;
      left  <= left_n;
    end
  end

`ifdef HAZARD_STATS_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge Clock) begin
    if (Reset) begin
      StallCycles   <= '0;
      RedirectCount <= '0;
    end else begin
      if (IDEXFlush) StallCycles   <= sat_inc(StallCycles);
      if (Redirect)  RedirectCount <= sat_inc(RedirectCount);
    end
  end
`else
  assign StallCycles   = '0;
  assign RedirectCount = '0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_id_hazard_redirect_ctrl.sv
// Scoreboard bench for id_hazard_redirect_ctrl (LOAD_LAT=2, FLUSH_SLOTS=3, CNT_W=4).
`timescale 1ns/1ps
module tb_id_hazard_redirect_ctrl;
  logic       Clock, Reset, IDValid, IDUsesRs, IDUsesRt, IDIsBranch, IDIsJump, IDIsJumpReg;
  logic       BranchTaken, EXRegWrite, EXMemRead, MEMRegWrite, MEMMemRead, WBRegWrite;
  logic [4:0] IDRs, IDRt, EXDest, MEMDest, WBDest;
  logic [1:0] FwdSelA, FwdSelB;
  logic       PCWriteEnable, IFIDWriteEnable, IDEXFlush, IFIDFlush, Redirect;
  logic [3:0] StallCycles, RedirectCount;

  id_hazard_redirect_ctrl #(.REG_AW(5), .LOAD_LAT(2), .FLUSH_SLOTS(3), .CNT_W(4)) dut (
    .Clock(Clock), .Reset(Reset), .IDValid(IDValid), .IDRs(IDRs), .IDRt(IDRt),
    .IDUsesRs(IDUsesRs), .IDUsesRt(IDUsesRt), .IDIsBranch(IDIsBranch), .IDIsJump(IDIsJump),
    .IDIsJumpReg(IDIsJumpReg), .BranchTaken(BranchTaken), .EXRegWrite(EXRegWrite),
    .EXMemRead(EXMemRead), .EXDest(EXDest), .MEMRegWrite(MEMRegWrite), .MEMMemRead(MEMMemRead),
    .MEMDest(MEMDest), .WBRegWrite(WBRegWrite), .WBDest(WBDest), .FwdSelA(FwdSelA),
    .FwdSelB(FwdSelB), .PCWriteEnable(PCWriteEnable), .IFIDWriteEnable(IFIDWriteEnable),
    .IDEXFlush(IDEXFlush), .IFIDFlush(IFIDFlush), .Redirect(Redirect),
    .StallCycles(StallCycles), .RedirectCount(RedirectCount));

  // {PCWriteEnable, IFIDWriteEnable, IDEXFlush, IFIDFlush, Redirect}
  localparam logic [4:0] RUN_O = 5'b11000;
  localparam logic [4:0] STL_O = 5'b00100;
  localparam logic [4:0] RED_O = 5'b11011;
  localparam logic [4:0] FLS_O = 5'b11010;
  localparam logic [4:0] RST_O = 5'b00110;

  typedef struct packed {
    logic [7:0] cyc;
    logic [1:0] fa, fb;
    logic [4:0] ctl;
    logic [3:0] sc, rc;
  } exp_t;

  exp_t       sb[$];
  int         n_cmp = 0, n_bad = 0;
  logic [7:0] cyc = 0;
  logic [3:0] sc_m = 0, rc_m = 0;

  initial begin
    Clock = 0;
    forever #5 Clock = ~Clock;
  end

  task automatic idle();
    IDValid = 0; IDUsesRs = 0; IDUsesRt = 0; IDIsBranch = 0; IDIsJump = 0; IDIsJumpReg = 0;
    BranchTaken = 0; EXRegWrite = 0; EXMemRead = 0; MEMRegWrite = 0; MEMMemRead = 0;
    WBRegWrite = 0; IDRs = 0; IDRt = 0; EXDest = 0; MEMDest = 0; WBDest = 0;
  endtask

  task automatic step(input logic [1:0] fa, input logic [1:0] fb, input logic [4:0] ctl);
    exp_t e;
    e.cyc = cyc; e.fa = fa; e.fb = fb; e.ctl = ctl;
`ifdef HAZARD_STATS_EN
    e.sc = sc_m; e.rc = rc_m;
`else
    e.sc = 4'd0; e.rc = 4'd0;
`endif
    sb.push_back(e);
    if (Reset) begin
      sc_m = 0; rc_m = 0;
    end else begin
      if (ctl[2] && sc_m != 4'hF) sc_m = sc_m + 4'd1;
      if (ctl[0] && rc_m != 4'hF) rc_m = rc_m + 4'd1;
    end
    cyc = cyc + 8'd1;
    @(posedge Clock); #1;
  endtask

  task automatic chk(input string nm, input logic [7:0] c, input logic [3:0] act, input logic [3:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0h, required %0h", nm, c, act, req);
    end
  endtask

  // Monitor: outputs are combinational, so every cycle presents a response.
  always @(negedge Clock) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("fwd_a",    e.cyc, {2'b0, FwdSelA},       {2'b0, e.fa});
      chk("fwd_b",    e.cyc, {2'b0, FwdSelB},       {2'b0, e.fb});
      chk("pc_we",    e.cyc, {3'b0, PCWriteEnable},   {3'b0, e.ctl[4]});
      chk("ifid_we",  e.cyc, {3'b0, IFIDWriteEnable}, {3'b0, e.ctl[3]});
      chk("idex_fl",  e.cyc, {3'b0, IDEXFlush},       {3'b0, e.ctl[2]});
      chk("ifid_fl",  e.cyc, {3'b0, IFIDFlush},       {3'b0, e.ctl[1]});
      chk("redirect", e.cyc, {3'b0, Redirect},        {3'b0, e.ctl[0]});
      chk("stall_cnt", e.cyc, StallCycles,   e.sc);
      chk("redir_cnt", e.cyc, RedirectCount, e.rc);
    end
  end

  initial begin
    Reset = 1; idle();
    @(posedge Clock); #1;
    step(0, 0, RST_O);
    Reset = 0; step(0, 0, RUN_O);
    // load-use on rs, LOAD_LAT=2
    idle(); IDValid = 1; IDRs = 8; IDUsesRs = 1; IDRt = 9; IDUsesRt = 1;
    EXRegWrite = 1; EXMemRead = 1; EXDest = 8;
    step(0, 0, STL_O); step(0, 0, STL_O);
    idle(); IDValid = 1; IDRs = 8; IDUsesRs = 1; WBRegWrite = 1; WBDest = 8;
    step(2, 0, RUN_O);
    // EX ALU feeding a branch, then taken redirect with 3 squash slots
    idle(); IDValid = 1; IDIsBranch = 1; IDRs = 9; IDUsesRs = 1; IDUsesRt = 1;
    EXRegWrite = 1; EXDest = 9;
    step(0, 0, STL_O);
    EXRegWrite = 0; EXDest = 0; MEMRegWrite = 1; MEMDest = 9; BranchTaken = 1;
    step(1, 0, RED_O);
    EXRegWrite = 1; EXMemRead = 1; EXDest = 9;
    step(1, 0, FLS_O); step(1, 0, FLS_O);
    idle(); step(0, 0, RUN_O);
    idle(); IDValid = 1; IDIsBranch = 1; step(0, 0, RUN_O);
    idle(); IDIsBranch = 1; BranchTaken = 1; step(0, 0, RUN_O);
    // jump
    idle(); IDValid = 1; IDIsJump = 1; step(0, 0, RED_O);
    idle(); step(0, 0, FLS_O); step(0, 0, FLS_O); step(0, 0, RUN_O);
    // jr waits for rs, then redirects
    idle(); IDValid = 1; IDIsJump = 1; IDIsJumpReg = 1; IDRs = 4; IDUsesRs = 1;
    EXRegWrite = 1; EXDest = 4;
    step(0, 0, STL_O);
    EXRegWrite = 0; EXDest = 0; MEMRegWrite = 1; MEMDest = 4;
    step(1, 0, RED_O);
    idle(); step(0, 0, FLS_O); step(0, 0, FLS_O);
    // forwarding priority and exclusions
    idle(); IDValid = 1; IDRs = 5; IDUsesRs = 1; IDRt = 7; IDUsesRt = 1;
    MEMRegWrite = 1; MEMDest = 5; WBRegWrite = 1; WBDest = 5;
    step(1, 0, RUN_O);
    WBDest = 7; step(1, 2, RUN_O);
    MEMMemRead = 1; WBDest = 5; step(2, 0, RUN_O);
    idle(); IDValid = 1; IDIsBranch = 1; IDUsesRs = 1; IDUsesRt = 1;
    EXRegWrite = 1; EXMemRead = 1; MEMRegWrite = 1; WBRegWrite = 1;
    step(0, 0, RUN_O);
    idle(); IDValid = 1; IDRs = 5; EXRegWrite = 1; EXMemRead = 1; EXDest = 5;
    MEMRegWrite = 1; MEMDest = 5;
    step(0, 0, RUN_O);
    IDValid = 0; IDUsesRs = 1; step(0, 0, RUN_O);
    // MEM load feeding a branch
    idle(); IDValid = 1; IDIsBranch = 1; IDRs = 3; IDUsesRs = 1;
    MEMRegWrite = 1; MEMMemRead = 1; MEMDest = 3;
    step(0, 0, STL_O);
    MEMRegWrite = 0; MEMMemRead = 0; MEMDest = 0; WBRegWrite = 1; WBDest = 3;
    step(2, 0, RUN_O);
    // EX load feeding a branch on rt: LOAD_LAT+1 = 3 stall cycles
    idle(); IDValid = 1; IDIsBranch = 1; IDRt = 6; IDUsesRt = 1;
    EXRegWrite = 1; EXMemRead = 1; EXDest = 6;
    step(0, 0, STL_O); step(0, 0, STL_O); step(0, 0, STL_O);
    EXRegWrite = 0; EXMemRead = 0; EXDest = 0; WBRegWrite = 1; WBDest = 6; BranchTaken = 1;
    step(0, 2, RED_O);
    idle(); step(0, 0, FLS_O); step(0, 0, FLS_O); step(0, 0, RUN_O);
    // stall beats taken branch; reset in 2nd stall cycle
    idle(); IDValid = 1; IDIsBranch = 1; BranchTaken = 1; IDRs = 2; IDUsesRs = 1;
    EXRegWrite = 1; EXMemRead = 1; EXDest = 2;
    step(0, 0, STL_O);
    Reset = 1; step(0, 0, RST_O);
    Reset = 0; idle(); step(0, 0, RUN_O);
    // reset during flush
    idle(); IDValid = 1; IDIsJump = 1; step(0, 0, RED_O);
    idle(); step(0, 0, FLS_O);
    Reset = 1; step(0, 0, RST_O);
    Reset = 0; step(0, 0, RUN_O);
    // 21 stall cycles drive a 4-bit counter into saturation
    for (int k = 0; k < 7; k++) begin
      idle(); IDValid = 1; IDIsBranch = 1; IDRs = 1; IDUsesRs = 1;
      EXRegWrite = 1; EXMemRead = 1; EXDest = 1;
      step(0, 0, STL_O); step(0, 0, STL_O); step(0, 0, STL_O);
      idle(); step(0, 0, RUN_O);
    end
    for (int w = 0; w < 4 && sb.size() > 0; w++) @(negedge Clock);
    #1;
    if (sb.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d responses unchecked, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
